// File: rtl/press_debouncer.sv
// Pushbutton debouncer: two-flop synchronizer followed by a press/held/release FSM
// with optional auto-repeat press pulses while the button is held.
module press_debouncer #(
    parameter int DEB_CYCLES     = 50000,
    parameter int BTN_ACTIVE_LOW = 1,
    parameter int REPEAT_EN      = 0,
    parameter int REPEAT_DELAY   = 25000000,
    parameter int REPEAT_PERIOD  = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press,
    output logic held,
    output logic release_pulse  // "release" is a reserved word in SystemVerilog
);

    localparam int CNT_W  = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam int RCNT_W = (REPEAT_DELAY > 2) ? $clog2(REPEAT_DELAY) : 1;
    // A period longer than the delay cannot be reached by reloading; clamp to a full restart.
    localparam int RELOAD_I = (REPEAT_PERIOD >= REPEAT_DELAY) ? 0 : REPEAT_DELAY - REPEAT_PERIOD;

    localparam logic [CNT_W-1:0]  CNT_MAX     = CNT_W'(DEB_CYCLES - 1);
    localparam logic [RCNT_W-1:0] RCNT_MAX    = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] RCNT_RELOAD = RCNT_W'(RELOAD_I);
    localparam logic              IDLE_LVL    = (BTN_ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        REL_CHK
    } state_t;

    state_t            state;
    logic              sync1;
    logic              sync2;
    logic              btn_s;
    logic [CNT_W-1:0]  cnt;
    logic [RCNT_W-1:0] rcnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= IDLE_LVL;
            sync2 <= IDLE_LVL;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    assign btn_s = (BTN_ACTIVE_LOW != 0) ? ~sync2 : sync2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            rcnt          <= '0;
            press         <= 1'b0;
            held          <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press         <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (btn_s) begin
                        state <= PRESS_CHK;
                        cnt   <= '0;
                    end
                end
                PRESS_CHK: begin
                    if (!btn_s) begin
                        state <= IDLE;
                    end else if (cnt == CNT_MAX) begin
                        state <= HELD;
                        press <= 1'b1;
                        held  <= 1'b1;
                        rcnt  <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!btn_s) begin
                        state <= REL_CHK;
                        cnt   <= '0;
                    end else if (REPEAT_EN != 0) begin
                        if (rcnt == RCNT_MAX) begin
                            press <= 1'b1;
                            rcnt  <= RCNT_RELOAD;
                        end else begin
                            rcnt <= rcnt + RCNT_W'(1);
                        end
                    end
                end
                REL_CHK: begin
                    // Bounce back to pressed: resume HELD with the repeat counter untouched.
                    if (btn_s) begin
                        state <= HELD;
                    end else if (cnt == CNT_MAX) begin
                        state         <= IDLE;
                        held          <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_press_debouncer.sv
// Scoreboard bench: expected pulse events (kind, edge number) are queued when stimulus is
// driven and popped when a DUT pulse is seen; held is checked at chosen edges.
module tb_press_debouncer;

    typedef struct {
        bit rel;
        int cyc;
    } ev_t;

    logic clk;
    logic rst_n;
    logic btn_a, btn_b;
    logic press_a, held_a, rel_a;
    logic press_b, held_b, rel_b;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    ev_t  q_a[$];
    ev_t  q_b[$];

    press_debouncer #(
        .DEB_CYCLES(4), .BTN_ACTIVE_LOW(1), .REPEAT_EN(0),
        .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_a),
        .press(press_a), .held(held_a), .release_pulse(rel_a)
    );

    press_debouncer #(
        .DEB_CYCLES(4), .BTN_ACTIVE_LOW(1), .REPEAT_EN(1),
        .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) u_rep (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_b),
        .press(press_b), .held(held_b), .release_pulse(rel_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc = number of rising edges seen so far
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic got(input string tag, input bit is_rel, input int n, input ev_t e);
        if (n == 0) begin
            chk({tag, "_unexpected"}, 1, 0);
        end else begin
            chk({tag, "_kind"}, int'(is_rel), int'(e.rel));
            chk({tag, "_edge"}, cyc, e.cyc);
        end
    endtask

    task automatic goto(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    task automatic push_a(input bit rel, input int c);
        ev_t e;
        e.rel = rel;
        e.cyc = c;
        q_a.push_back(e);
    endtask

    task automatic push_b(input bit rel, input int c);
        ev_t e;
        e.rel = rel;
        e.cyc = c;
        q_b.push_back(e);
    endtask

    always @(negedge clk) begin
        ev_t e;
        int  n;
        e.rel = 1'b0;
        e.cyc = 0;
        if (press_a) begin
            n = q_a.size();
            if (n != 0) e = q_a.pop_front();
            got("a_press", 1'b0, n, e);
        end
        if (rel_a) begin
            n = q_a.size();
            if (n != 0) e = q_a.pop_front();
            got("a_release", 1'b1, n, e);
        end
        if (press_b) begin
            n = q_b.size();
            if (n != 0) e = q_b.pop_front();
            got("b_press", 1'b0, n, e);
        end
        if (rel_b) begin
            n = q_b.size();
            if (n != 0) e = q_b.pop_front();
            got("b_release", 1'b1, n, e);
        end
    end

    initial begin
        rst_n = 1'b0;
        btn_a = 1'b1;
        btn_b = 1'b1;
        goto(2);
        chk("rst_press", int'(press_a), 0);
        chk("rst_held", int'(held_a), 0);
        chk("rst_release", int'(rel_a), 0);
        chk("rst_held_b", int'(held_b), 0);
        rst_n = 1'b1;

        // clean press, stable from edge 10
        goto(9);  btn_a = 1'b0; push_a(1'b0, 16);
        goto(15); chk("clean_held_pre", int'(held_a), 0);
        goto(16); chk("clean_held", int'(held_a), 1);

        // release bounce of 2 cycles: no pulse, held stays up
        goto(25); btn_a = 1'b1;
        goto(27); btn_a = 1'b0;
        for (int k = 28; k <= 32; k++) begin
            goto(k); chk("relbounce_held", int'(held_a), 1);
        end

        // release stable from edge 40 (no repeats with REPEAT_EN=0 despite long hold)
        goto(39); btn_a = 1'b1; push_a(1'b1, 46);
        goto(45); chk("release_held_pre", int'(held_a), 1);
        goto(46); chk("release_held", int'(held_a), 0);

        // bounce: low 3, high 2, low stable from edge 65
        goto(59); btn_a = 1'b0;
        goto(62); btn_a = 1'b1;
        goto(64); btn_a = 1'b0; push_a(1'b0, 71);
        goto(70); chk("bounce_held_pre", int'(held_a), 0);
        goto(71); chk("bounce_held", int'(held_a), 1);
        goto(79); btn_a = 1'b1; push_a(1'b1, 86);

        // glitch: low for 3 cycles only
        goto(89); btn_a = 1'b0;
        goto(92); btn_a = 1'b1;
        for (int k = 90; k <= 100; k++) begin
            goto(k); chk("glitch_held", int'(held_a), 0);
        end

        // reset while in PRESS_CHK with cnt=2, button kept low
        goto(109); btn_a = 1'b0;
        goto(114); rst_n = 1'b0;
        goto(115); rst_n = 1'b1;
        chk("midrst_press", int'(press_a), 0);
        chk("midrst_held", int'(held_a), 0);
        push_a(1'b0, 122);
        goto(121); chk("postrst_held_pre", int'(held_a), 1 - 1);
        goto(122); chk("postrst_held", int'(held_a), 1);

        // reset while HELD: no release pulse, fresh press afterwards
        goto(124); rst_n = 1'b0;
        goto(125); rst_n = 1'b1;
        chk("heldrst_held", int'(held_a), 0);
        chk("heldrst_release", int'(rel_a), 0);
        push_a(1'b0, 132);
        goto(132); chk("heldrst_repress_held", int'(held_a), 1);
        goto(139); btn_a = 1'b1; push_a(1'b1, 146);
        goto(146); chk("final_rel_held", int'(held_a), 0);

        // auto-repeat on the second instance, press stable from edge 160
        goto(159); btn_b = 1'b0;
        push_b(1'b0, 166); push_b(1'b0, 176); push_b(1'b0, 179); push_b(1'b0, 182);
        goto(166); chk("rep_held", int'(held_b), 1);
        goto(182); btn_b = 1'b1; push_b(1'b1, 189);
        goto(188); chk("rep_held_pre_rel", int'(held_b), 1);
        goto(189); chk("rep_held_rel", int'(held_b), 0);

        goto(200);
        chk("sb_a_empty", q_a.size(), 0);
        chk("sb_b_empty", q_b.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
